// File: rtl/vga_pixel_pipeline_pkg.sv
// Shared constants and types for the VGA pixel pipeline and its timing bench.
package vga_pixel_pipeline_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Cycles from a coordinate entering the pipeline to its pixel leaving it.
  localparam int PIPE_LATENCY = 3;

  // RGB332 byte layout: red in [7:5], green in [4:2], blue in [1:0].
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  // Multiply by a constant as a sum of shifted copies; with a constant k
  // this folds to plain adders (k=320 gives (v<<8)+(v<<6)).
  function automatic logic [31:0] shift_add_mul(input logic [31:0] v, input logic [31:0] k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_pixel_pipeline_if.sv
// Framebuffer read port: pipeline issues a strobe + address, memory returns
// the byte one cycle later.
interface vga_pixel_pipeline_if #(
  parameter int ADDR_W = 17
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;

  modport master (output fb_rd_en, output fb_addr, input fb_data);
  modport slave  (input fb_rd_en, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_pixel_pipeline_delay_line.sv
// Fixed-depth shift register used to keep syncs and control flags aligned
// with the pixel data path.
module vga_pixel_pipeline_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift one tap per cycle; reset loads the idle value into every tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Three-stage pixel fetch: address/read, capture, colour out. The framebuffer
// is half resolution, so each byte covers a 2x2 block of screen pixels.
module vga_pixel_pipeline
  import vga_pixel_pipeline_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [9:0]        h_pixel,
  input  logic [8:0]        v_pixel,
  input  logic              display_enable,
  input  logic [ADDR_W-1:0] fb_base,
  vga_pixel_pipeline_if.master fb,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_done
);

  logic              active_in, last_in, show_in, row_ok, done_evt;
  logic [ADDR_W-1:0] addr_next, base_latched;
  logic              s1_active, s1_last, line_seen;
  logic              rd_d, show_s2;
  logic [7:0]        pix_hold, pix_byte;
  rgb332_t           rgb_q;

  assign active_in = (h_pixel < 10'(H_ACTIVE)) && (v_pixel < 9'(V_ACTIVE));
  assign last_in   = active_in && (h_pixel == 10'(H_ACTIVE - 1)) && (v_pixel == 9'(V_ACTIVE - 1));
  assign show_in   = active_in && display_enable;
  // Never read past the last buffer row if the screen is taller than 2x the buffer.
  assign row_ok    = 32'(v_pixel[8:1]) < 32'(FB_HEIGHT);
  // The previous input was the last visible pixel and this one is not.
  assign done_evt  = s1_last && !active_in;
  assign addr_next = ADDR_W'(32'(base_latched)
                     + shift_add_mul(32'(v_pixel[8:1]), 32'(FB_WIDTH))
                     + 32'(h_pixel[9:1]));

  // Stage 1: register the address; read only when it moves to a new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb.fb_rd_en <= 1'b0;
      fb.fb_addr  <= '0;
      s1_active   <= 1'b0;
      s1_last     <= 1'b0;
    end else begin
      fb.fb_rd_en <= active_in && row_ok && (!s1_active || (addr_next != fb.fb_addr));
      fb.fb_addr  <= addr_next;
      s1_active   <= active_in;
      s1_last     <= last_in;
    end
  end

  // Swap buffers only at the first vertical-blanking line after visible video.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_latched <= '0;
      line_seen    <= 1'b0;
    end else if (active_in) begin
      line_seen <= 1'b1;
    end else if (line_seen && (v_pixel >= 9'(V_ACTIVE))) begin
      base_latched <= fb_base;
      line_seen    <= 1'b0;
    end
  end

  assign pix_byte = rd_d ? fb.fb_data : pix_hold;

  // Stage 2: take the returned byte when our read was issued, else keep the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d     <= 1'b0;
      pix_hold <= '0;
    end else begin
      rd_d     <= fb.fb_rd_en;
      pix_hold <= pix_byte;
    end
  end

  // Stage 3: drive colour for visible, enabled pixels; black otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_q <= '0;
    else        rgb_q <= show_s2 ? rgb332_t'(pix_byte) : '0;
  end

  assign red   = rgb_q.red;
  assign green = rgb_q.green;
  assign blue  = rgb_q.blue;

  vga_pixel_pipeline_delay_line #(
    .WIDTH(3), .DEPTH(PIPE_LATENCY), .RESET_VAL(3'b110)
  ) u_sync_dl (
    .clk(clk), .reset(reset),
    .d({h_sync_in, v_sync_in, done_evt}),
    .q({h_sync, v_sync, frame_done})
  );

  vga_pixel_pipeline_delay_line #(
    .WIDTH(1), .DEPTH(PIPE_LATENCY - 1), .RESET_VAL(1'b0)
  ) u_show_dl (
    .clk(clk), .reset(reset),
    .d(show_in),
    .q(show_s2)
  );

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench for vga_pixel_pipeline with a simple framebuffer responder.
module tb_vga_pixel_pipeline;

  logic        clk;
  logic        reset;
  logic        h_sync_in, v_sync_in, display_enable;
  logic [9:0]  h_pixel;
  logic [8:0]  v_pixel;
  logic [16:0] fb_base;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        h_sync, v_sync, frame_done;

  int checks = 0;
  int errors = 0;

  vga_pixel_pipeline_if #(.ADDR_W(17)) fb_if ();

  vga_pixel_pipeline dut (
    .clk(clk), .reset(reset),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .h_pixel(h_pixel), .v_pixel(v_pixel),
    .display_enable(display_enable), .fb_base(fb_base),
    .fb(fb_if),
    .red(red), .green(green), .blue(blue),
    .h_sync(h_sync), .v_sync(v_sync), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_byte(input logic [16:0] a);
    return a[7:0] ^ 8'hE3;
  endfunction

  // Framebuffer: byte appears the cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    fb_if.fb_data <= fb_if.fb_rd_en ? mem_byte(fb_if.fb_addr) : 8'h5C;
  end

  typedef struct {
    logic [9:0]  h;
    logic [8:0]  v;
    logic        de, hs, vs;
    logic        rd;
    logic [16:0] addr;
    logic [7:0]  rgb;
    logic        done;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input int h, input int v, input logic de, input logic hs,
                              input logic vs, input logic rd, input int addr,
                              input logic [7:0] rgb, input logic done);
    vec_t r;
    r.h = 10'(h); r.v = 9'(v); r.de = de; r.hs = hs; r.vs = vs;
    r.rd = rd; r.addr = 17'(addr); r.rgb = rgb; r.done = done;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_px(input int h, input int v, input logic de, input logic hs, input logic vs);
    h_pixel = 10'(h);
    v_pixel = 9'(v);
    display_enable = de;
    h_sync_in = hs;
    v_sync_in = vs;
  endtask

  int done_cnt, done_pos;

  initial begin
    //            h    v    de hs vs  rd addr     rgb    done
    vecs[0]  = mk(0,   0,   1, 0, 1,  1, 0,       8'hE3, 0);
    vecs[1]  = mk(1,   0,   1, 1, 0,  0, 0,       8'hE3, 0);
    vecs[2]  = mk(2,   0,   1, 1, 1,  1, 1,       8'hE2, 0);
    vecs[3]  = mk(2,   2,   1, 0, 0,  1, 321,     8'hA2, 0);
    vecs[4]  = mk(2,   2,   1, 1, 1,  0, 321,     8'hA2, 0);
    vecs[5]  = mk(3,   2,   1, 1, 1,  0, 321,     8'hA2, 0);
    vecs[6]  = mk(3,   2,   1, 1, 1,  0, 321,     8'hA2, 0);
    vecs[7]  = mk(640, 10,  1, 0, 0,  0, 1920,    8'h00, 0);
    vecs[8]  = mk(4,   2,   1, 1, 1,  1, 322,     8'hA1, 0);
    vecs[9]  = mk(5,   2,   0, 1, 1,  0, 322,     8'h00, 0);
    vecs[10] = mk(6,   2,   0, 1, 1,  1, 323,     8'h00, 0);
    vecs[11] = mk(7,   2,   1, 1, 1,  0, 323,     8'hA0, 0);
    vecs[12] = mk(639, 479, 1, 0, 1,  1, 76799,   8'h1C, 0);
    vecs[13] = mk(640, 479, 1, 1, 0,  0, 76800,   8'h00, 1);

    reset = 1'b0;
    fb_base = '0;
    set_px(700, 10, 1, 1, 1);
    #12;
    chk("reset rd_en", 32'(fb_if.fb_rd_en), 0);
    chk("reset addr", 32'(fb_if.fb_addr), 0);
    chk("reset rgb", 32'({red, green, blue}), 0);
    chk("reset h_sync", 32'(h_sync), 1);
    chk("reset v_sync", 32'(v_sync), 1);
    chk("reset frame_done", 32'(frame_done), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Table: stage-1 outputs one cycle after drive, stage-3 outputs three cycles after.
    for (int i = 0; i < NV + 3; i++) begin
      @(negedge clk);
      if (i >= 1 && i - 1 < NV) begin
        chk($sformatf("v%0d rd_en", i - 1), 32'(fb_if.fb_rd_en), 32'(vecs[i-1].rd));
        chk($sformatf("v%0d addr", i - 1), 32'(fb_if.fb_addr), 32'(vecs[i-1].addr));
      end
      if (i >= 3) begin
        chk($sformatf("v%0d rgb", i - 3), 32'({red, green, blue}), 32'(vecs[i-3].rgb));
        chk($sformatf("v%0d h_sync", i - 3), 32'(h_sync), 32'(vecs[i-3].hs));
        chk($sformatf("v%0d v_sync", i - 3), 32'(v_sync), 32'(vecs[i-3].vs));
        chk($sformatf("v%0d frame_done", i - 3), 32'(frame_done), 32'(vecs[i-3].done));
      end
      if (i < NV) set_px(int'(vecs[i].h), int'(vecs[i].v), vecs[i].de, vecs[i].hs, vecs[i].vs);
      else        set_px(700, 10, 1, 1, 1);
    end

    // frame_done is a single pulse, four cycles after the last pixel is driven.
    done_cnt = 0;
    done_pos = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        done_pos = k;
      end
      if (k == 0)      set_px(639, 479, 1, 1, 1);
      else if (k == 1) set_px(640, 479, 1, 1, 1);
      else             set_px(700, 10, 1, 1, 1);
    end
    chk("frame_done pulse count", 32'(done_cnt), 1);
    chk("frame_done pulse cycle", 32'(done_pos), 4);

    // Buffer swap: a mid-frame base change waits for vertical blanking.
    @(negedge clk);
    fb_base = 17'h12C00;
    set_px(10, 100, 1, 1, 1);
    @(negedge clk);
    chk("base mid-frame addr", 32'(fb_if.fb_addr), 16005);
    chk("base mid-frame rd_en", 32'(fb_if.fb_rd_en), 1);
    set_px(5, 479, 1, 1, 1);
    @(negedge clk);
    chk("base last line addr", 32'(fb_if.fb_addr), 76482);
    set_px(0, 480, 1, 1, 1);
    @(negedge clk);
    chk("vblank rd_en", 32'(fb_if.fb_rd_en), 0);
    set_px(0, 0, 1, 1, 1);
    @(negedge clk);
    chk("new frame addr", 32'(fb_if.fb_addr), 32'h12C00);
    chk("new frame rd_en", 32'(fb_if.fb_rd_en), 1);
    fb_base = 17'h00100;
    set_px(0, 2, 1, 1, 1);
    @(negedge clk);
    chk("base held addr", 32'(fb_if.fb_addr), 77120);

    // Reset in the middle of a line.
    set_px(8, 4, 1, 0, 0);
    repeat (4) @(negedge clk);
    chk("pre-reset rgb", 32'({red, green, blue}), 32'h67);
    chk("pre-reset h_sync", 32'(h_sync), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid reset rgb", 32'({red, green, blue}), 0);
    chk("mid reset h_sync", 32'(h_sync), 1);
    chk("mid reset v_sync", 32'(v_sync), 1);
    chk("mid reset rd_en", 32'(fb_if.fb_rd_en), 0);
    chk("mid reset addr", 32'(fb_if.fb_addr), 0);
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("post reset addr", 32'(fb_if.fb_addr), 644);
    chk("post reset rd_en", 32'(fb_if.fb_rd_en), 1);
    @(negedge clk);
    chk("post reset rgb c2", 32'({red, green, blue}), 0);
    chk("post reset h_sync c2", 32'(h_sync), 1);
    repeat (2) @(negedge clk);
    chk("post reset rgb c4", 32'({red, green, blue}), 32'h67);
    chk("post reset h_sync c4", 32'(h_sync), 0);
    chk("post reset v_sync c4", 32'(v_sync), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
